mult_8_8: RTL and testbench
===========================

MULT_8_8 -- requirements
Module: mult_8_8

Interface
REQ-001 The block SHALL have no parameters; operand and product widths are fixed at 8, 8 and 16 bits.
REQ-002 clk  input  1  single clock; rising edge; used only by the registered product path.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 a  input  8  multiplicand, unsigned.
REQ-005 b  input  8  multiplier, unsigned.
REQ-006 c  output  16  combinational unsigned product a*b.
REQ-007 c_q  output  16  registered copy of c.
REQ-008 c_vld  output  1  high when c_q holds a product captured after reset.

Function
REQ-009 c SHALL equal a*b, unsigned, full 16-bit width, for all 65536 input pairs, with no truncation or overflow.
REQ-010 c SHALL be purely combinational: it settles within the same cycle as an a/b change and has zero clock latency, independent of clk and rst_n.
REQ-011 The product SHALL be built structurally:
- 8 partial-product rows pp[i] = a AND {8{b[i]}}, each weighted by 2^i;
- reduction by an explicit half-adder/full-adder array or carry-save tree;
- a final carry-propagate adder.
- The behavioural * operator SHALL NOT be used in the datapath.
REQ-012 Half-adder and full-adder cells SHALL be written as gate equations: sum = XOR; carry = majority/AND-OR.
REQ-013 The final adder carry-out beyond bit 15 SHALL be provably zero, since 255*255 = 65025 < 65536.
REQ-014 c SHALL contain no latches and no combinational loops.
REQ-015 With MULT_8_8_REG_EN defined, c_q SHALL load c on every rising clk edge (1-cycle latency), and c_vld SHALL go high at the first rising edge after rst_n deasserts and stay high.
REQ-016 A change of a/b between edges SHALL affect c immediately and c_q only at the next edge.

Reset
REQ-017 While rst_n = 0, c_q SHALL be 16'h0000 and c_vld SHALL be 0, asynchronously and regardless of clk.
REQ-018 Reset asserted mid-operation SHALL clear c_q/c_vld immediately and SHALL NOT affect c.
REQ-019 After rst_n rises, c_q SHALL hold 0 until the first rising clk edge.

Configuration
REQ-020 Macro MULT_8_8_REG_EN defined: the c_q/c_vld output register is compiled in, per REQ-015 and REQ-017.
REQ-021 Macro MULT_8_8_REG_EN undefined: no flip-flops are instantiated; c_q SHALL be wired to c; c_vld SHALL be tied to 1; clk and rst_n remain as ports but are unused.
REQ-022 c behaviour SHALL be identical with and without the macro.

Verification
REQ-023 a=0, b=0 -> c=16'h0000; a=255, b=255 -> c=16'hFE01 (65025), in the same time step.
REQ-024 a=1, b=255 -> c=255; a=128, b=2 -> c=256; a=170, b=85 -> c=14450 (16'h3872).
REQ-025 Random test: at least 101 random a/b pairs applied every 20 ns; a self-check flag (c == a*b, computed in the bench) SHALL stay 1 throughout; additionally run an exhaustive sweep of all 65536 pairs with 0 mismatches.
REQ-026 MULT_8_8_REG_EN defined, rst_n=0: c_q=0 and c_vld=0. Release reset, apply a=200, b=100 -> c=20000 immediately; c_q=20000 and c_vld=1 after the next rising edge.
REQ-027 MULT_8_8_REG_EN defined, c_q=20000: assert rst_n=0 between clock edges -> c_q=0 and c_vld=0 at once, while c still equals a*b.
REQ-028 MULT_8_8_REG_EN undefined: c_q tracks c combinationally for all REQ-023/024 vectors, and c_vld=1 at all times.

Source files
------------

// File: rtl/mult_8_8.sv
`default_nettype none
// ============================================================================
//  Module   : mult_8_8
//  Purpose  : Unsigned 8x8 -> 16-bit structural multiplier. Partial-product
//             rows are reduced by a carry-save array of full adders and then
//             resolved by a ripple carry-propagate adder. An output register
//             stage for the product is optional.
//  Config   : MULT_8_8_REG_EN
//               defined   -> c_q/c_vld are driven by a flop stage with
//                            asynchronous active-low reset.
//               undefined -> no flops; c_q follows c combinationally and
//                            c_vld is tied high.
//  Ports    : clk    in   1  rising-edge clock (register stage only)
//             rst_n  in   1  asynchronous active-low reset (register stage only)
//             a      in   8  multiplicand, unsigned
//             b      in   8  multiplier, unsigned
//             c      out 16  combinational product a*b
//             c_q    out 16  registered copy of c
//             c_vld  out  1  c_q holds a product captured since reset
//  Revision : 1.0  initial release
// ============================================================================
module mult_8_8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] c,
  output logic [15:0] c_q,
  output logic        c_vld
);

  // --------------------------------------------------------------------------
  // Adder cells as gate equations
  // --------------------------------------------------------------------------
  function automatic logic ha_sum(input logic x, input logic y);
    return x ^ y;
  endfunction

  function automatic logic ha_carry(input logic x, input logic y);
    return x & y;
  endfunction

  function automatic logic fa_sum(input logic x, input logic y, input logic z);
    return x ^ y ^ z;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // --------------------------------------------------------------------------
  // Partial products: row i is a AND b[i], already shifted to weight 2^i.
  // --------------------------------------------------------------------------
  logic [15:0] w_pp [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_pp
    assign w_pp[gi] = {8'h00, (a & {8{b[gi]}})} << gi;
  end

  // --------------------------------------------------------------------------
  // Carry-save reduction followed by a ripple carry-propagate adder.
  //
  // Each row folds one partial product into a (sum, carry) vector pair with a
  // column of full adders. Carries out of bit 15 are not built anywhere: the
  // pair always sums to the product modulo 2^16, and the product never
  // exceeds 255*255 = 65025 < 2^16, so those carries are necessarily zero.
  // --------------------------------------------------------------------------
  logic [15:0] w_s   [8];   // carry-save sum vector after row r
  logic [15:0] w_cy  [8];   // carry-save carry vector after row r
  logic [15:1] w_cpc;       // carry chain of the final adder
  logic [15:0] w_p;         // resolved product

  always_comb begin
    for (int r = 0; r < 8; r++) begin
      w_s[r]  = '0;
      w_cy[r] = '0;
    end
    w_cpc = '0;
    w_p   = '0;

    w_s[0] = w_pp[0];

    for (int r = 1; r < 8; r++) begin
      for (int k = 0; k < 16; k++) begin
        w_s[r][k] = fa_sum(w_s[r-1][k], w_cy[r-1][k], w_pp[r][k]);
      end
      // Carry vector is shifted up one column; bit 0 stays zero.
      for (int k = 0; k < 15; k++) begin
        w_cy[r][k+1] = fa_carry(w_s[r-1][k], w_cy[r-1][k], w_pp[r][k]);
      end
    end

    // Bit 0 has no incoming carry, so a half adder suffices.
    w_p[0]   = ha_sum(w_s[7][0], w_cy[7][0]);
    w_cpc[1] = ha_carry(w_s[7][0], w_cy[7][0]);
    for (int k = 1; k < 15; k++) begin
      w_p[k]     = fa_sum(w_s[7][k], w_cy[7][k], w_cpc[k]);
      w_cpc[k+1] = fa_carry(w_s[7][k], w_cy[7][k], w_cpc[k]);
    end
    // Top bit: carry-out beyond bit 15 is provably zero, so only the sum.
    w_p[15] = fa_sum(w_s[7][15], w_cy[7][15], w_cpc[15]);
  end

  assign c = w_p;

  // --------------------------------------------------------------------------
  // Optional output register
  // --------------------------------------------------------------------------
`ifdef MULT_8_8_REG_EN
  logic [15:0] r_c_q;
  logic        r_c_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_q   <= 16'h0000;
      r_c_vld <= 1'b0;
    end else begin
      r_c_q   <= c;
      r_c_vld <= 1'b1;
    end
  end

  assign c_q   = r_c_q;
  assign c_vld = r_c_vld;
`else
  // clk and rst_n stay on the port list so both builds share one footprint.
  logic w_unused;
  assign w_unused = &{1'b0, clk, rst_n};

  assign c_q   = c;
  assign c_vld = 1'b1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mult_8_8.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_8_8
//  Purpose  : Self-checking bench for mult_8_8. Works for both builds: when
//             MULT_8_8_REG_EN is defined the registered-path expectations
//             apply, otherwise c_q must mirror c and c_vld must stay high.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_8_8;

`ifdef MULT_8_8_REG_EN
  localparam bit REG_EN = 1'b1;
`else
  localparam bit REG_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] c;
  logic [15:0] c_q;
  logic        c_vld;

  int total;
  int bad;

  logic [15:0] sb_q [$];

  mult_8_8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .c_q   (c_q),
    .c_vld (c_vld)
  );

  always #10 clk = ~clk;

  // --------------------------------------------------------------------------
  task automatic test_reset();
    logic [15:0] exp_q;
    logic        exp_v;
    rst_n = 1'b0;
    a = 8'd12;
    b = 8'd13;
    repeat (2) @(posedge clk);
    #1;
    exp_q = REG_EN ? 16'd0 : 16'd156;
    exp_v = REG_EN ? 1'b0 : 1'b1;
    total++;
    if (c !== 16'd156) begin
      bad++; $display("FAIL reset_c: got %0d want %0d", c, 16'd156);
    end
    total++;
    if (c_q !== exp_q) begin
      bad++; $display("FAIL reset_cq: got %0d want %0d", c_q, exp_q);
    end
    total++;
    if (c_vld !== exp_v) begin
      bad++; $display("FAIL reset_vld: got %0b want %0b", c_vld, exp_v);
    end
    // Release between edges: register must hold its reset value until the edge.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (c_q !== exp_q) begin
      bad++; $display("FAIL reset_release_hold: got %0d want %0d", c_q, exp_q);
    end
    @(posedge clk);
    #1;
    total++;
    if (c_q !== 16'd156) begin
      bad++; $display("FAIL reset_first_edge_cq: got %0d want %0d", c_q, 16'd156);
    end
    total++;
    if (c_vld !== 1'b1) begin
      bad++; $display("FAIL reset_first_edge_vld: got %0b want 1", c_vld);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_vectors();
    logic [7:0]  va [6];
    logic [7:0]  vb [6];
    logic [15:0] vc [6];
    logic [15:0] exp_pop;
    va[0] = 8'd0;   vb[0] = 8'd0;   vc[0] = 16'h0000;
    va[1] = 8'd255; vb[1] = 8'd255; vc[1] = 16'hFE01;
    va[2] = 8'd1;   vb[2] = 8'd255; vc[2] = 16'd255;
    va[3] = 8'd128; vb[3] = 8'd2;   vc[3] = 16'd256;
    va[4] = 8'd170; vb[4] = 8'd85;  vc[4] = 16'h3872;
    va[5] = 8'd255; vb[5] = 8'd1;   vc[5] = 16'd255;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a = va[i];
      b = vb[i];
      sb_q.push_back(vc[i]);
      #1;
      total++;
      if (c !== vc[i]) begin
        bad++; $display("FAIL vec_c[%0d]: got %0d want %0d", i, c, vc[i]);
      end
      if (!REG_EN) begin
        total++;
        if (c_q !== vc[i]) begin
          bad++; $display("FAIL vec_cq_comb[%0d]: got %0d want %0d", i, c_q, vc[i]);
        end
      end
      @(posedge clk);
      #1;
      exp_pop = sb_q.pop_front();
      total++;
      if (c_q !== exp_pop) begin
        bad++; $display("FAIL vec_cq[%0d]: got %0d want %0d", i, c_q, exp_pop);
      end
      total++;
      if (c_vld !== 1'b1) begin
        bad++; $display("FAIL vec_vld[%0d]: got %0b want 1", i, c_vld);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  // New pair every 20 ns; c checked immediately, c_q checked before the edge
  // (old value when registered) and after it (scoreboard head).
  task automatic test_random();
    logic [15:0] exp;
    logic [15:0] exp_pop;
    logic [15:0] last_q;
    logic [15:0] exp_mid;
    bit          ok_flag;
    ok_flag = 1'b1;
    last_q  = 16'd0;
    for (int n = 0; n < 101; n++) begin
      @(negedge clk);
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      exp = 16'(a) * 16'(b);
      sb_q.push_back(exp);
      #1;
      total++;
      if (c !== exp) begin
        bad++; ok_flag = 1'b0;
        $display("FAIL rand_c[%0d]: a=%0d b=%0d got %0d want %0d", n, a, b, c, exp);
      end
      if (n > 0) begin
        exp_mid = REG_EN ? last_q : exp;
        total++;
        if (c_q !== exp_mid) begin
          bad++; ok_flag = 1'b0;
          $display("FAIL rand_cq_mid[%0d]: got %0d want %0d", n, c_q, exp_mid);
        end
      end
      @(posedge clk);
      #1;
      exp_pop = sb_q.pop_front();
      last_q  = exp_pop;
      total++;
      if (c_q !== exp_pop) begin
        bad++; ok_flag = 1'b0;
        $display("FAIL rand_cq[%0d]: got %0d want %0d", n, c_q, exp_pop);
      end
      total++;
      if (c_vld !== 1'b1) begin
        bad++; ok_flag = 1'b0;
        $display("FAIL rand_vld[%0d]: got %0b want 1", n, c_vld);
      end
    end
    total++;
    if (ok_flag !== 1'b1) begin
      bad++; $display("FAIL rand_flag: got %0b want 1", ok_flag);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_exhaustive();
    logic [15:0] exp;
    for (int i = 0; i < 65536; i++) begin
      a = 8'(i >> 8);
      b = 8'(i);
      exp = 16'(a) * 16'(b);
      #1;
      total++;
      if (c !== exp) begin
        bad++; $display("FAIL sweep_c: a=%0d b=%0d got %0d want %0d", a, b, c, exp);
      end
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reg_load();
    logic [15:0] exp_cur;
    logic [15:0] exp_q;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_cur = 16'(a) * 16'(b);
    exp_q   = REG_EN ? 16'd0 : exp_cur;
    total++;
    if (c_q !== exp_q) begin
      bad++; $display("FAIL load_rst_cq: got %0d want %0d", c_q, exp_q);
    end
    total++;
    if (c_vld !== !REG_EN) begin
      bad++; $display("FAIL load_rst_vld: got %0b want %0b", c_vld, !REG_EN);
    end
    rst_n = 1'b1;
    a = 8'd200;
    b = 8'd100;
    #1;
    total++;
    if (c !== 16'd20000) begin
      bad++; $display("FAIL load_c: got %0d want 20000", c);
    end
    exp_q = REG_EN ? 16'd0 : 16'd20000;
    total++;
    if (c_q !== exp_q) begin
      bad++; $display("FAIL load_cq_pre_edge: got %0d want %0d", c_q, exp_q);
    end
    @(posedge clk);
    #1;
    total++;
    if (c_q !== 16'd20000) begin
      bad++; $display("FAIL load_cq: got %0d want 20000", c_q);
    end
    total++;
    if (c_vld !== 1'b1) begin
      bad++; $display("FAIL load_vld: got %0b want 1", c_vld);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reset pulled mid-cycle while c_q holds 20000 (a=200, b=100 still applied).
  task automatic test_reset_mid();
    logic [15:0] exp_q;
    #4;
    rst_n = 1'b0;
    #1;
    exp_q = REG_EN ? 16'd0 : 16'd20000;
    total++;
    if (c_q !== exp_q) begin
      bad++; $display("FAIL mid_rst_cq: got %0d want %0d", c_q, exp_q);
    end
    total++;
    if (c_vld !== !REG_EN) begin
      bad++; $display("FAIL mid_rst_vld: got %0b want %0b", c_vld, !REG_EN);
    end
    total++;
    if (c !== 16'd20000) begin
      bad++; $display("FAIL mid_rst_c: got %0d want 20000", c);
    end
    // Clock edges while held in reset must not load the register.
    @(posedge clk);
    #1;
    total++;
    if (c_q !== exp_q) begin
      bad++; $display("FAIL mid_rst_held_cq: got %0d want %0d", c_q, exp_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (c_q !== 16'd20000) begin
      bad++; $display("FAIL mid_rst_recover_cq: got %0d want 20000", c_q);
    end
    total++;
    if (c_vld !== 1'b1) begin
      bad++; $display("FAIL mid_rst_recover_vld: got %0b want 1", c_vld);
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    rst_n = 1'b0;
    a     = 8'd0;
    b     = 8'd0;
    test_reset();
    test_vectors();
    test_random();
    test_reg_load();
    test_reset_mid();
    test_exhaustive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
